// File: rtl/fp_norm_round_seq.sv
// Sequential normalise + round stage for the binary32 add/sub datapath.
// Normalises one bit per cycle, rounds per RISC-V rm, raises {OF, UF, NX}.
module fp_norm_round_seq #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_res,
  input  logic                   carry,
  input  logic [MAN_W-1:0]       mantissa_sum,
  input  logic [MAN_W-1:0]       grs,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [2:0]             rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic [2:0]             flags
);

  localparam int VW = 2*MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int RW = EXP_W + MAN_W;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [VW-1:0]          v_q, v_d;
  logic signed [EW-1:0]   e_q, e_d;
  logic                   sign_q, sign_d;
  logic [2:0]             rm_q, rm_d;
  logic                   zero_q, zero_d;
  logic [RW-1:0]          result_q, result_d;
  logic [2:0]             flags_q, flags_d;

  // Rounding datapath, evaluated from the normalised work register.
  logic [MAN_W-1:0]       m, m_rnd;
  logic                   g, r, s, nx, inc, of;
  logic [MAN_W:0]         m_sum;
  logic signed [EW-1:0]   e_rnd;
  logic [EXP_W-1:0]       e_fld;
  logic [RW-1:0]          inf_v, maxf_v, rnd_res;
  logic [2:0]             rnd_flags;

  always_comb begin
    m  = v_q[VW-2 -: MAN_W];
    g  = v_q[MAN_W-1];
    r  = v_q[MAN_W-2];
    s  = |v_q[MAN_W-3:0];
    nx = g | r | s;
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = nx & sign_q;
      RM_RUP:  inc = nx & ~sign_q;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | m[0]);
    endcase
    m_sum = {1'b0, m} + {{MAN_W{1'b0}}, inc};
    if (m_sum[MAN_W]) begin
      m_rnd = {1'b1, {(MAN_W-1){1'b0}}};
      e_rnd = e_q + E_ONE;
    end else begin
      m_rnd = m_sum[MAN_W-1:0];
      e_rnd = e_q;
    end
    of     = (e_rnd >= E_MAX);
    // Subnormals carry E==1 with a clear hidden bit; field encodes as 0.
    e_fld  = m_rnd[MAN_W-1] ? e_rnd[EXP_W-1:0] : '0;
    inf_v  = {sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
    maxf_v = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {(MAN_W-1){1'b1}}};
    rnd_res   = {sign_q, e_fld, m_rnd[MAN_W-2:0]};
    rnd_flags = {1'b0, nx & (e_fld == '0), nx};
    if (zero_q) begin
      rnd_res   = {(rm_q == RM_RDN), {(RW-1){1'b0}}};
      rnd_flags = 3'b000;
    end else if (of) begin
      rnd_flags = 3'b101;
      case (rm_q)
        RM_RTZ:  rnd_res = maxf_v;
        RM_RDN:  rnd_res = sign_q ? inf_v : maxf_v;
        RM_RUP:  rnd_res = sign_q ? maxf_v : inf_v;
        default: rnd_res = inf_v;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    e_d      = e_q;
    sign_d   = sign_q;
    rm_d     = rm_q;
    zero_d   = zero_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          v_d     = {carry, mantissa_sum, grs};
          e_d     = EW'(exp_in);
          sign_d  = sign_res;
          rm_d    = rm;
          zero_d  = 1'b0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (v_q[VW-1]) begin
          // Right shift folds the dropped bit into the sticky position.
          v_d     = {1'b0, v_q[VW-1:2], v_q[1] | v_q[0]};
          e_d     = e_q + E_ONE;
          state_d = S_ROUND;
        end else if (v_q == '0) begin
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else if (v_q[VW-2] || (e_q == E_ONE)) begin
          state_d = S_ROUND;
        end else begin
          v_d = v_q << 1;
          e_d = e_q - E_ONE;
        end
      end
      S_ROUND: begin
        result_d = rnd_res;
        flags_d  = rnd_flags;
        state_d  = S_OUT;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      v_q      <= '0;
      e_q      <= '0;
      sign_q   <= 1'b0;
      rm_q     <= 3'b000;
      zero_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      e_q      <= e_d;
      sign_q   <= sign_d;
      rm_q     <= rm_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Bench for fp_norm_round_seq: directed corner cases, handshake/reset checks,
// and random sums compared against an exact-remainder rounding model.
module tb_fp_norm_round_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, sign_res, carry;
  logic [23:0] mantissa_sum, grs;
  logic [7:0]  exp_in;
  logic [2:0]  rm;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int total = 0;
  int bad   = 0;

  fp_norm_round_seq #(.MAN_W(24), .EXP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_res(sign_res), .carry(carry), .mantissa_sum(mantissa_sum), .grs(grs),
    .exp_in(exp_in), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Exact value model: locate the leading one, scale, round from the
  // discarded remainder compared against one half ulp.
  function automatic void model(input bit c, input bit [23:0] m, input bit [23:0] g,
                                input bit [7:0] ex, input bit sg, input bit [2:0] r,
                                output bit [31:0] res, output bit [2:0] fl, output int lat);
    longint unsigned v, keep, rem, half;
    int p, k, e, ef;
    bit up, nx;
    v = {15'd0, c, m, g};
    if (v == 0) begin
      res = {(r == 3'b010), 31'd0};
      fl  = 3'b000;
      lat = 2;
      return;
    end
    p = 48;
    while (!v[p]) p--;
    if (p == 48) begin
      keep = v >> 25;
      rem  = v & ((64'd1 << 25) - 1);
      half = 64'd1 << 24;
      e    = ex + 1;
      k    = 0;
    end else begin
      k = 47 - p;
      if (k > ex - 1) k = ex - 1;
      v    = v << k;
      keep = v >> 24;
      rem  = v & 64'hFF_FFFF;
      half = 64'd1 << 23;
      e    = ex - k;
    end
    lat = k + 2;
    nx  = (rem != 0);
    case (r)
      3'b001:  up = 1'b0;
      3'b010:  up = nx && sg;
      3'b011:  up = nx && !sg;
      3'b100:  up = (rem >= half);
      default: up = (rem > half) || (rem == half && keep[0]);
    endcase
    keep = keep + {63'd0, up};
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e++;
    end
    if (e >= 255) begin
      fl = 3'b101;
      case (r)
        3'b001:  res = {sg, 31'h7F7FFFFF};
        3'b010:  res = sg ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF};
        3'b011:  res = sg ? {sg, 31'h7F7FFFFF} : {sg, 31'h7F800000};
        default: res = {sg, 31'h7F800000};
      endcase
    end else begin
      ef  = (keep >= (64'd1 << 23)) ? e : 0;
      res = {sg, ef[7:0], keep[22:0]};
      fl  = {1'b0, nx && (ef == 0), nx};
    end
  endfunction

  task automatic do_op(input string tag, input bit c, input bit [23:0] m, input bit [23:0] g,
                       input bit [7:0] ex, input bit sg, input bit [2:0] r,
                       output bit [31:0] got_res, output bit [2:0] got_fl);
    bit [31:0] er;
    bit [2:0]  efl;
    int el, cyc, w;
    model(c, m, g, ex, sg, r, er, efl, el);
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    carry = c; mantissa_sum = m; grs = g; exp_in = ex; sign_res = sg; rm = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " busy"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk({tag, " latency"}, 32'(cyc), 32'(el));
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, 32'(flags), 32'(efl));
    got_res = result;
    got_fl  = flags;
    @(posedge clk); #1;
    chk({tag, " drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit [31:0] res, held;
    bit [2:0]  fl, heldf;
    int w, seen;
    bit [23:0] mm, gg;
    bit [7:0]  ee;
    bit        cc;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_res = 1'b0; carry = 1'b0; mantissa_sum = '0; grs = '0; exp_in = 8'd1; rm = 3'b000;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset result", result, 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    do_op("t1", 1'b1, 24'h0, 24'h0, 8'd127, 1'b0, 3'b000, res, fl);
    chk("t1 const", res, 32'h40000000);
    do_op("t2a", 1'b0, 24'h000001, 24'h0, 8'd127, 1'b0, 3'b000, res, fl);
    chk("t2a const", res, 32'h34000000);
    do_op("t2b", 1'b0, 24'h000001, 24'h0, 8'd2, 1'b0, 3'b000, res, fl);
    chk("t2b const", {res, 1'b0} >> 1, 32'h00000002);
    chk("t2b flg", 32'(fl), 32'd0);
    do_op("t3rne", 1'b0, 24'h800001, 24'h800000, 8'd127, 1'b0, 3'b000, res, fl);
    chk("t3rne const", res, 32'h3F800002);
    do_op("t3rtz", 1'b0, 24'h800001, 24'h800000, 8'd127, 1'b0, 3'b001, res, fl);
    chk("t3rtz const", res, 32'h3F800001);
    do_op("t3rdn", 1'b0, 24'h800001, 24'h800000, 8'd127, 1'b1, 3'b010, res, fl);
    chk("t3rdn const", res, 32'hBF800002);
    chk("t3rdn nx", 32'(fl), 32'd1);
    do_op("t4rne", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 3'b000, res, fl);
    chk("t4rne const", res, 32'h7F800000);
    chk("t4rne flg", 32'(fl), 32'd5);
    do_op("t4rtz", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 3'b001, res, fl);
    chk("t4rtz const", res, 32'h7F7FFFFF);
    do_op("t5rne", 1'b0, 24'h0, 24'h0, 8'd100, 1'b1, 3'b000, res, fl);
    chk("t5rne const", res, 32'h00000000);
    do_op("t5rdn", 1'b0, 24'h0, 24'h0, 8'd100, 1'b1, 3'b010, res, fl);
    chk("t5rdn const", res, 32'h80000000);
    do_op("uf", 1'b0, 24'h000003, 24'h400000, 8'd1, 1'b0, 3'b011, res, fl);

    // Backpressure: result must hold and no second item may be accepted.
    carry = 1'b0; mantissa_sum = 24'h800001; grs = 24'h800000; exp_in = 8'd127;
    sign_res = 1'b0; rm = 3'b000; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    mantissa_sum = 24'h123456; exp_in = 8'd50;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    chk("stall first", result, 32'h3F800002);
    held = result; heldf = flags;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall result", result, held);
      chk("stall flags", 32'(flags), 32'(heldf));
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall release", 32'(out_valid), 32'd0);
    chk("stall idle", 32'(in_ready), 32'd1);

    // Abort mid-normalisation.
    carry = 1'b0; mantissa_sum = 24'h000001; grs = '0; exp_in = 8'd127; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("abort ghost", 32'(seen), 32'd0);

    for (int i = 0; i < 60; i++) begin
      cc = 1'b0;
      gg = 24'($urandom);
      mm = 24'($urandom);
      case ($urandom_range(0, 3))
        0: cc = 1'b1;
        1: mm[23] = 1'b1;
        2: mm = mm >> $urandom_range(1, 23);
        default: begin mm = '0; gg = gg >> $urandom_range(0, 23); end
      endcase
      case ($urandom_range(0, 2))
        0: ee = 8'($urandom_range(1, 30));
        1: ee = 8'($urandom_range(248, 254));
        default: ee = 8'($urandom_range(1, 254));
      endcase
      if ($urandom_range(0, 7) == 0) begin cc = 1'b1; mm = 24'hFFFFFF; gg = 24'hFFFFFF; end
      do_op("rand", cc, mm, gg, ee, 1'($urandom), 3'($urandom_range(0, 7)), res, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
